// File: rtl/rendering_sdiv_18s_9s_9_seq.sv
// Sequential signed restoring divider, one quotient bit per cycle, C truncation semantics.
// Optional saturation of dout on overflow when RENDERING_SDIV_SAT_EN is defined.
module rendering_sdiv_18s_9s_9_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 18,
    parameter int din1_WIDTH = 9,
    parameter int dout_WIDTH = 9
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf
);

    localparam int MW = din0_WIDTH + 1;
    localparam int RW = din1_WIDTH + 1;
    localparam int CW = (din0_WIDTH > 1) ? $clog2(din0_WIDTH) : 1;

    localparam logic [MW-1:0] QPosMax = MW'((1 << (dout_WIDTH - 1)) - 1);
    localparam logic [MW-1:0] QNegMax = MW'(1 << (dout_WIDTH - 1));
    localparam logic [dout_WIDTH-1:0] DoutMax = dout_WIDTH'((1 << (dout_WIDTH - 1)) - 1);
    localparam logic [dout_WIDTH-1:0] DoutMin = dout_WIDTH'(1 << (dout_WIDTH - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_d;
    logic [CW-1:0]           r_cnt;
    logic [MW-1:0]           r_dvd;
    logic [RW-1:0]           r_dsr;
    logic [RW-1:0]           r_prem;
    logic [MW-1:0]           r_quo;
    logic                    r_s0;
    logic                    r_s1;
    logic                    r_dz;
    logic [din1_WIDTH-1:0]   r_din0_lo;
    logic [dout_WIDTH-1:0]   r_dout;
    logic [din1_WIDTH-1:0]   r_rem;
    logic                    r_ovf;

    logic [MW-1:0]           w_ext0;
    logic [MW-1:0]           w_abs0;
    logic [RW-1:0]           w_ext1;
    logic [RW-1:0]           w_abs1;
    logic [RW-1:0]           w_shift;
    logic [RW:0]             w_diff;
    logic                    w_qbit;
    logic                    w_neg;
    logic                    w_big;
    logic [dout_WIDTH-1:0]   w_qlo;
    logic [din1_WIDTH-1:0]   w_rmag;
    logic [dout_WIDTH-1:0]   w_dout_fix;
    logic [din1_WIDTH-1:0]   w_rem_fix;
    logic                    w_ovf_fix;
    logic                    w_accept;
    logic                    w_unused;

    assign in_rdy   = (r_state == S_IDLE);
    assign out_vld  = (r_state == S_DONE);
    assign dout     = r_dout;
    assign rem      = r_rem;
    assign ovf      = r_ovf;
    assign w_accept = in_vld && in_rdy;

    // Extending by one bit before negating keeps -2^(W-1) exact as a magnitude.
    assign w_ext0 = {din0[din0_WIDTH-1], din0};
    assign w_abs0 = din0[din0_WIDTH-1] ? (~w_ext0 + MW'(1)) : w_ext0;
    assign w_ext1 = {din1[din1_WIDTH-1], din1};
    assign w_abs1 = din1[din1_WIDTH-1] ? (~w_ext1 + RW'(1)) : w_ext1;

    // Partial remainder stays below |divisor| <= 2^(din1_WIDTH-1), so its MSB is always 0.
    assign w_shift = {r_prem[RW-2:0], r_dvd[din0_WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {1'b0, r_dsr};
    assign w_qbit  = ~w_diff[RW];

    assign w_neg  = r_s0 ^ r_s1;
    assign w_big  = w_neg ? (r_quo > QNegMax) : (r_quo > QPosMax);
    assign w_qlo  = r_quo[dout_WIDTH-1:0];
    assign w_rmag = r_prem[din1_WIDTH-1:0];

    always_comb begin
        w_ovf_fix  = r_dz | w_big;
        w_dout_fix = w_neg ? (~w_qlo + dout_WIDTH'(1)) : w_qlo;
        w_rem_fix  = r_s0 ? (~w_rmag + din1_WIDTH'(1)) : w_rmag;
`ifdef RENDERING_SDIV_SAT_EN
        if (r_dz) begin
            w_dout_fix = r_s0 ? DoutMin : DoutMax;
            w_rem_fix  = '0;
        end else if (w_big) begin
            w_dout_fix = w_neg ? DoutMin : DoutMax;
        end
`else
        if (r_dz) begin
            w_dout_fix = '1;
            w_rem_fix  = r_din0_lo;
        end
`endif
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_state_d = S_CALC;
            S_CALC: if (r_cnt == '0) w_state_d = S_FIX;
            S_FIX:  w_state_d = S_DONE;
            S_DONE: if (out_rdy) w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_prem    <= '0;
            r_quo     <= '0;
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
            r_dz      <= 1'b0;
            r_din0_lo <= '0;
            r_dout    <= '0;
            r_rem     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= CW'(din0_WIDTH - 1);
                        r_dvd     <= w_abs0;
                        r_dsr     <= w_abs1;
                        r_prem    <= '0;
                        r_quo     <= '0;
                        r_s0      <= din0[din0_WIDTH-1];
                        r_s1      <= din1[din1_WIDTH-1];
                        r_dz      <= (din1 == '0);
                        r_din0_lo <= din0[din1_WIDTH-1:0];
                    end
                end
                S_CALC: begin
                    r_cnt  <= r_cnt - CW'(1);
                    r_dvd  <= {r_dvd[MW-2:0], 1'b0};
                    r_prem <= w_qbit ? w_diff[RW-1:0] : w_shift;
                    r_quo  <= {r_quo[MW-2:0], w_qbit};
                end
                S_FIX: begin
                    r_dout <= w_dout_fix;
                    r_rem  <= w_rem_fix;
                    r_ovf  <= w_ovf_fix;
                end
                default: ;
            endcase
        end
    end

    assign w_unused = ^{1'(ID), r_dvd[MW-1], r_prem[RW-1], r_din0_lo, DoutMax, DoutMin};

endmodule

// File: tb/tb_rendering_sdiv_18s_9s_9_seq.sv
// Randomized self-checking bench for rendering_sdiv_18s_9s_9_seq against an integer-division model.
// Honours RENDERING_SDIV_SAT_EN when the same macro is defined for the bench.
module tb_rendering_sdiv_18s_9s_9_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [17:0] din0 = '0;
    logic [8:0]  din1 = '0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [8:0]  dout;
    logic [8:0]  rem;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ap_clk = ~ap_clk;

    rendering_sdiv_18s_9s_9_seq #(
        .ID        (1),
        .din0_WIDTH(18),
        .din1_WIDTH(9),
        .dout_WIDTH(9)
    ) u_dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .in_vld (in_vld),
        .in_rdy (in_rdy),
        .din0   (din0),
        .din1   (din1),
        .out_vld(out_vld),
        .out_rdy(out_rdy),
        .dout   (dout),
        .rem    (rem),
        .ovf    (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // C-style division reference: truncation toward zero, remainder follows dividend.
    task automatic model(input int a, input int b, output logic [8:0] e_q,
                         output logic [8:0] e_r, output logic e_ovf);
        int q;
        int r;
        if (b == 0) begin
            e_ovf = 1'b1;
`ifdef RENDERING_SDIV_SAT_EN
            e_q = (a >= 0) ? 9'd255 : 9'h100;
            e_r = 9'd0;
`else
            e_q = 9'h1FF;
            r   = a;
            e_r = r[8:0];
`endif
        end else begin
            q     = a / b;
            r     = a % b;
            e_ovf = (q > 255) || (q < -256);
            e_q   = q[8:0];
            e_r   = r[8:0];
`ifdef RENDERING_SDIV_SAT_EN
            if (e_ovf) e_q = (q > 0) ? 9'd255 : 9'h100;
`endif
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge ap_clk);
        while (!in_rdy && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        if (!in_rdy) check("in_rdy_timeout", 32'(in_rdy), 32'd1);
    endtask

    task automatic start(input int a, input int b);
        wait_ready();
        din0   = 18'(a);
        din1   = 9'(b);
        in_vld = 1'b1;
        @(posedge ap_clk);
        #1 in_vld = 1'b0;
    endtask

    // Counts cycles from the accept cycle (inclusive) until out_vld is seen.
    task automatic wait_result(output int lat);
        lat = 1;
        @(negedge ap_clk);
        while (!out_vld && lat < 60) begin
            @(posedge ap_clk);
            lat++;
            @(negedge ap_clk);
        end
        if (!out_vld) check("out_vld_timeout", 32'(out_vld), 32'd1);
    endtask

    task automatic accept_result();
        out_rdy = 1'b1;
        @(posedge ap_clk);
        #1 out_rdy = 1'b0;
    endtask

    task automatic run_div(input string tag, input int a, input int b, input bit chk_lat);
        logic [8:0] e_q;
        logic [8:0] e_r;
        logic       e_ovf;
        int         lat;
        model(a, b, e_q, e_r, e_ovf);
        start(a, b);
        wait_result(lat);
        if (chk_lat) check({tag, "_lat"}, 32'(lat), 32'd20);
        check({tag, "_dout"}, 32'(dout), 32'(e_q));
        check({tag, "_rem"}, 32'(rem), 32'(e_r));
        check({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
        accept_result();
    endtask

    initial begin
        logic [8:0] h_q;
        logic [8:0] h_r;
        logic       h_ovf;
        int         lat;
        int         a;
        int         b;

        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_in_rdy", 32'(in_rdy), 32'd1);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        run_div("d1000_7", 1000, 7, 1'b1);
        run_div("dm1000_7", -1000, 7, 1'b1);
        run_div("d1000_m7", 1000, -7, 1'b0);
        run_div("d100000_3", 100000, 3, 1'b0);
        run_div("d5_0", 5, 0, 1'b0);
        run_div("dm5_0", -5, 0, 1'b0);
        run_div("dmin_m1", -131072, -1, 1'b0);
        run_div("d255_1", 255, 1, 1'b0);
        run_div("dm256_1", -256, 1, 1'b0);
        run_div("d256_1", 256, 1, 1'b0);
        run_div("dm257_1", -257, 1, 1'b0);
        run_div("dmax_m256", 131071, -256, 1'b0);

        // Back-pressure: result held, inputs ignored while DONE.
        model(1000, 7, h_q, h_r, h_ovf);
        start(1000, 7);
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            din0   = 18'($urandom);
            din1   = 9'($urandom);
            in_vld = i[0];
            check("bp_out_vld", 32'(out_vld), 32'd1);
            check("bp_in_rdy", 32'(in_rdy), 32'd0);
            check("bp_dout", 32'(dout), 32'(h_q));
            check("bp_rem", 32'(rem), 32'(h_r));
            @(negedge ap_clk);
        end
        in_vld = 1'b0;
        check("bp_hold_dout", 32'(dout), 32'(h_q));
        accept_result();
        @(negedge ap_clk);
        check("bp_idle_in_rdy", 32'(in_rdy), 32'd1);
        check("bp_idle_out_vld", 32'(out_vld), 32'd0);

        // Reset during CALC discards the division in flight.
        start(1000, 7);
        repeat (7) @(posedge ap_clk);
        #1 ap_rst = 1'b1;
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        check("mrst_out_vld", 32'(out_vld), 32'd0);
        check("mrst_dout", 32'(dout), 32'd0);
        check("mrst_rem", 32'(rem), 32'd0);
        check("mrst_ovf", 32'(ovf), 32'd0);
        check("mrst_in_rdy", 32'(in_rdy), 32'd1);
        for (int i = 0; i < 25; i++) begin
            @(negedge ap_clk);
            check("mrst_no_stale", 32'(out_vld), 32'd0);
        end
        run_div("post_rst", 1000, 7, 1'b1);

        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 262143)) - 131072;
            b = int'($urandom_range(0, 511)) - 256;
            if (i % 4 == 0) a = a / 512;
            if (i % 16 == 5) b = 0;
            run_div("rand", a, b, (i % 8 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
